regfile_bypass: RTL and testbench

Parametrised multi-port register file for the processor datapath; the successor to the fixed 8×32, single-write register file. It adds two write ports with defined priority, same-cycle write-to-read forwarding on both read ports, an optional hard-wired zero register, a per-register pending scoreboard for multi-cycle producers, and a registered debug read port that replaces the flat per-register debug outputs.

---
 rtl/regfile_bypass.sv | 131 +++++++++++++
 tb/tb_regfile_bypass.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_bypass.sv
// regfile_bypass
//   Parametrised register file with two write ports, write-to-read forwarding
//   on both read ports, optional hard-wired zero register, a per-register
//   pending scoreboard for multi-cycle producers and a registered debug port.
//
// Ports
//   clk, n_rst           clock (rising edge), asynchronous active-low reset
//   ra1/ra2 -> rd1/rd2   combinational read with forwarding from this cycle's writes
//   busy1/busy2          addressed register is pending and not written this cycle
//   we0/wa0/wd0          write port 0
//   we1/wa1/wd1          write port 1 (wins over port 0 on the same address)
//   claim/claim_addr     mark a register pending (producer issued)
//   claim_err/err_clr    sticky double-claim flag and its clear
//   dbg_addr -> dbg_data registered, pre-write view of rf[dbg_addr]
module regfile_bypass #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              busy1,
  output logic              busy2,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd0,
  input  logic [DATA_W-1:0] wd1,
  input  logic              claim,
  input  logic [ADDR_W-1:0] claim_addr,
  output logic              claim_err,
  input  logic              err_clr,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] rf [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [DEPTH-1:0]  wr_hit;
  logic              we0_eff;
  logic              we1_eff;
  logic              claim_eff;
  logic              err_set;

  // True for the hard-wired zero register when it is enabled.
  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Forwarding read: port 1 beats port 0, both beat storage.
  function automatic logic [DATA_W-1:0] fwd_read(
    input logic [ADDR_W-1:0] ra,
    input logic              w0,
    input logic [ADDR_W-1:0] a0,
    input logic [DATA_W-1:0] d0,
    input logic              w1,
    input logic [ADDR_W-1:0] a1,
    input logic [DATA_W-1:0] d1,
    input logic [DATA_W-1:0] stored
  );
    if (is_zero(ra))           return '0;
    else if (w1 && (a1 == ra)) return d1;
    else if (w0 && (a0 == ra)) return d0;
    else                       return stored;
  endfunction

  // Any enabled write port targeting each register this cycle. Writes to a
  // hard-wired zero register still count here; pending[0] can never be set
  // in that configuration, so it makes no observable difference.
  always_comb begin
    wr_hit = '0;
    for (int a = 0; a < DEPTH; a++) begin
      wr_hit[a] = (we0 && (wa0 == ADDR_W'(a))) || (we1 && (wa1 == ADDR_W'(a)));
    end
  end

  assign we0_eff   = we0 && !is_zero(wa0);
  assign we1_eff   = we1 && !is_zero(wa1);
  assign claim_eff = claim && !is_zero(claim_addr);
  // A double claim is only an error if the earlier producer is not retiring
  // in the very same cycle.
  assign err_set   = claim_eff && pending[claim_addr] && !wr_hit[claim_addr];

  always_comb begin
    rd1 = fwd_read(ra1, we0, wa0, wd0, we1, wa1, wd1, rf[ra1]);
    rd2 = fwd_read(ra2, we0, wa0, wd0, we1, wa1, wd1, rf[ra2]);
  end

  // Forwarded data is valid this cycle, so a register being written is not busy.
  assign busy1 = !is_zero(ra1) && pending[ra1] && !wr_hit[ra1];
  assign busy2 = !is_zero(ra2) && pending[ra2] && !wr_hit[ra2];

  // Storage; port 1 is assigned last so it wins an address collision.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int a = 0; a < DEPTH; a++) rf[a] <= '0;
    end else begin
      if (we0_eff) rf[wa0] <= wd0;
      if (we1_eff) rf[wa1] <= wd1;
    end
  end

  // Scoreboard: a claim beats a retiring write to the same register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pending   <= '0;
      claim_err <= 1'b0;
    end else begin
      for (int a = 0; a < DEPTH; a++) begin
        if (claim_eff && (claim_addr == ADDR_W'(a))) pending[a] <= 1'b1;
        else if (wr_hit[a])                          pending[a] <= 1'b0;
      end
      if (err_set)      claim_err <= 1'b1;
      else if (err_clr) claim_err <= 1'b0;
    end
  end

  // ---- stage p0 -> p1: debug read, sampled before this edge's writes ----
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) dbg_data <= '0;
    else        dbg_data <= is_zero(dbg_addr) ? '0 : rf[dbg_addr];
  end

endmodule

// File: tb/tb_regfile_bypass.sv
module tb_regfile_bypass;

  logic        clk;
  logic        n_rst;
  logic [2:0]  ra1, ra2, wa0, wa1, claim_addr, dbg_addr;
  logic        we0, we1, claim, err_clr;
  logic [31:0] wd0, wd1;

  // Instance 0: ZERO_REG=0, instance 1: ZERO_REG=1, same stimulus.
  logic [31:0] rd1_z0, rd2_z0, dbg_z0, rd1_z1, rd2_z1, dbg_z1;
  logic        busy1_z0, busy2_z0, err_z0, busy1_z1, busy2_z1, err_z1;

  int checks   = 0;
  int failures = 0;
  bit run_cmp  = 0;

  regfile_bypass #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(0)) u_z0 (
    .clk(clk), .n_rst(n_rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_z0), .rd2(rd2_z0),
    .busy1(busy1_z0), .busy2(busy2_z0), .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1),
    .wd0(wd0), .wd1(wd1), .claim(claim), .claim_addr(claim_addr), .claim_err(err_z0),
    .err_clr(err_clr), .dbg_addr(dbg_addr), .dbg_data(dbg_z0));

  regfile_bypass #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(1)) u_z1 (
    .clk(clk), .n_rst(n_rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_z1), .rd2(rd2_z1),
    .busy1(busy1_z1), .busy2(busy2_z1), .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1),
    .wd0(wd0), .wd1(wd1), .claim(claim), .claim_addr(claim_addr), .claim_err(err_z1),
    .err_clr(err_clr), .dbg_addr(dbg_addr), .dbg_data(dbg_z1));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  logic [31:0] m_rf   [2][8];
  bit          m_pend [2][8];
  bit          m_err  [2];
  logic [31:0] m_dbg  [2];

  function automatic bit zr(input int k, input logic [2:0] a);
    return (k == 1) && (a == 3'd0);
  endfunction

  function automatic bit hit(input logic [2:0] a);
    return (we0 && wa0 == a) || (we1 && wa1 == a);
  endfunction

  function automatic logic [31:0] exp_rd(input int k, input logic [2:0] ra);
    if (zr(k, ra))            return 32'd0;
    if (we1 && wa1 == ra)     return wd1;
    if (we0 && wa0 == ra)     return wd0;
    return m_rf[k][ra];
  endfunction

  function automatic bit exp_busy(input int k, input logic [2:0] ra);
    return !zr(k, ra) && m_pend[k][ra] && !hit(ra);
  endfunction

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < 2; k++) begin
        for (int a = 0; a < 8; a++) begin m_rf[k][a] = 0; m_pend[k][a] = 0; end
        m_err[k] = 0; m_dbg[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit cl;
        cl = claim && !zr(k, claim_addr);
        m_dbg[k] = zr(k, dbg_addr) ? 32'd0 : m_rf[k][dbg_addr];
        if (cl && m_pend[k][claim_addr] && !hit(claim_addr)) m_err[k] = 1;
        else if (err_clr)                                    m_err[k] = 0;
        for (int a = 0; a < 8; a++) begin
          if (cl && claim_addr == 3'(a)) m_pend[k][a] = 1;
          else if (hit(3'(a)))           m_pend[k][a] = 0;
        end
        if (we0 && !zr(k, wa0)) m_rf[k][wa0] = wd0;
        if (we1 && !zr(k, wa1)) m_rf[k][wa1] = wd1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (run_cmp) begin
      chk("cmp_rd1_z0",  rd1_z0,   exp_rd(0, ra1));
      chk("cmp_rd2_z0",  rd2_z0,   exp_rd(0, ra2));
      chk("cmp_busy1_z0", 32'(busy1_z0), 32'(exp_busy(0, ra1)));
      chk("cmp_busy2_z0", 32'(busy2_z0), 32'(exp_busy(0, ra2)));
      chk("cmp_err_z0",  32'(err_z0), 32'(m_err[0]));
      chk("cmp_dbg_z0",  dbg_z0,   m_dbg[0]);
      chk("cmp_rd1_z1",  rd1_z1,   exp_rd(1, ra1));
      chk("cmp_rd2_z1",  rd2_z1,   exp_rd(1, ra2));
      chk("cmp_busy1_z1", 32'(busy1_z1), 32'(exp_busy(1, ra1)));
      chk("cmp_busy2_z1", 32'(busy2_z1), 32'(exp_busy(1, ra2)));
      chk("cmp_err_z1",  32'(err_z1), 32'(m_err[1]));
      chk("cmp_dbg_z1",  dbg_z1,   m_dbg[1]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic next();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; claim = 0; err_clr = 0;
  endtask

  initial begin
    n_rst = 1; idle();
    ra1 = 0; ra2 = 0; wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0;
    claim_addr = 0; dbg_addr = 0;
    #1 n_rst = 0;
    next(); next();
    n_rst = 1;
    run_cmp = 1;
    #1 chk("reset_dbg", dbg_z0, 32'd0);
    chk("reset_err", 32'(err_z0), 32'd0);

    // Write and forward
    we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; ra1 = 5;
    #1 chk("fwd_rd1", rd1_z0, 32'hDEADBEEF);
    next(); idle(); dbg_addr = 5;
    #1 chk("stored_rd1", rd1_z0, 32'hDEADBEEF);
    next();
    #1 chk("dbg_rf5", dbg_z0, 32'hDEADBEEF);

    // Dual-write collision: port 1 wins
    we0 = 1; we1 = 1; wa0 = 2; wa1 = 2; wd0 = 32'h11; wd1 = 32'h22; ra2 = 2;
    #1 chk("collide_fwd", rd2_z0, 32'h22);
    next(); idle();
    #1 chk("collide_stored", rd2_z0, 32'h22);

    // Zero register
    we0 = 1; wa0 = 0; wd0 = 32'h55; claim = 1; claim_addr = 0; ra1 = 0;
    #1 chk("zr1_fwd", rd1_z1, 32'd0);
    chk("zr0_fwd", rd1_z0, 32'h55);
    next(); idle();
    #1 chk("zr1_stored", rd1_z1, 32'd0);
    chk("zr0_stored", rd1_z0, 32'h55);
    chk("zr1_busy", 32'(busy1_z1), 32'd0);
    chk("zr0_busy", 32'(busy1_z0), 32'd1);
    chk("zr1_err", 32'(err_z1), 32'd0);

    // Scoreboard
    claim = 1; claim_addr = 3; ra1 = 3;
    #1 chk("claim_same_cycle", 32'(busy1_z0), 32'd0);
    next(); idle();
    #1 chk("claim_busy", 32'(busy1_z0), 32'd1);
    we0 = 1; wa0 = 3; wd0 = 32'h77;
    #1 chk("retire_busy", 32'(busy1_z0), 32'd0);
    chk("retire_rd1", rd1_z0, 32'h77);
    next(); idle();
    #1 chk("retired_busy", 32'(busy1_z0), 32'd0);
    claim = 1; claim_addr = 3; we1 = 1; wa1 = 3; wd1 = 32'h99;
    next(); idle();
    #1 chk("claimwr_busy", 32'(busy1_z0), 32'd1);
    chk("claimwr_rd1", rd1_z0, 32'h99);

    // Claim error
    claim = 1; claim_addr = 4;
    next();
    next(); idle();
    #1 chk("err_set", 32'(err_z0), 32'd1);
    next();
    #1 chk("err_held", 32'(err_z0), 32'd1);
    claim = 1; claim_addr = 4; err_clr = 1;
    next(); idle();
    #1 chk("err_set_wins", 32'(err_z0), 32'd1);
    err_clr = 1;
    next(); idle();
    #1 chk("err_clr", 32'(err_z0), 32'd0);
    // Re-claim of a register retiring this cycle is not an error
    claim = 1; claim_addr = 3; we0 = 1; wa0 = 3; wd0 = 32'h5A;
    next(); idle();
    #1 chk("reclaim_retire", 32'(err_z0), 32'd0);

    // Mid-operation reset
    ra1 = 3; ra2 = 4; dbg_addr = 5;
    #1 chk("pre_rst_busy2", 32'(busy2_z0), 32'd1);
    we0 = 1; wa0 = 6; wd0 = 32'hAA; claim = 1; claim_addr = 6;
    n_rst = 0;
    #1 chk("rst_busy1", 32'(busy1_z0), 32'd0);
    chk("rst_busy2", 32'(busy2_z0), 32'd0);
    chk("rst_dbg", dbg_z0, 32'd0);
    chk("rst_err", 32'(err_z0), 32'd0);
    n_rst = 1; idle();
    ra1 = 6;
    next();
    #1 chk("rst_dropped_wr", rd1_z0, 32'd0);
    chk("rst_rf5", dbg_z0, 32'd0);

    // Mixed traffic, checked by the model each cycle
    for (int i = 0; i < 40; i++) begin
      we0 = 1'($urandom); we1 = 1'($urandom); claim = 1'($urandom); err_clr = 1'($urandom_range(0, 3) == 0);
      wa0 = 3'($urandom); wa1 = 3'($urandom); claim_addr = 3'($urandom);
      wd0 = $urandom; wd1 = $urandom;
      ra1 = 3'($urandom); ra2 = 3'($urandom); dbg_addr = 3'($urandom);
      next();
    end
    idle();
    next(); next();
    run_cmp = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
